trap_ctrl: RTL and testbench

//   Sequences ECALL, EBREAK and MRET for the 5-stage pipelined core.

---
 rtl/trap_ctrl.sv | 129 ++++++++++++
 tb/tb_trap_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - ECALL/EBREAK/MRET sequencer and machine trap CSRs
module trap_ctrl #(
    parameter int              XLEN           = 32,
    parameter int              DRAIN_CYCLES   = 2,
    parameter logic [XLEN-1:0] MTVEC_RESET    = 32'h0000_0100,
    parameter bit              HALT_ON_EBREAK = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            EcallE,
    input  logic            EbreakE,
    input  logic            MretE,
    input  logic            StallE,
    input  logic [XLEN-1:0] PCE,
    input  logic            MtvecWrE,
    input  logic [XLEN-1:0] MtvecWdata,
    output logic            TrapStall,
    output logic            TrapFlush,
    output logic            TrapPCSel,
    output logic [XLEN-1:0] TrapPC,
    output logic [XLEN-1:0] Mepc,
    output logic [XLEN-1:0] Mcause,
    output logic [XLEN-1:0] Mtvec,
    output logic            Halted
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam int            CW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYCLES - 1);
    localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ret;
    logic          accept;

    // A request is taken only from an unstalled IDLE; reset masks it so outputs read clean during reset
    assign accept = (state == IDLE) && !StallE && !reset && (EcallE || EbreakE || MretE);

    // Stall/flush/redirect outputs; the accept cycle is Mealy so the pipeline freezes immediately
    always_comb begin
        TrapStall = 1'b0;
        TrapFlush = 1'b0;
        TrapPCSel = 1'b0;
        TrapPC    = '0;
        Halted    = 1'b0;
        case (state)
            IDLE: begin
                TrapStall = accept;
                TrapFlush = accept;
            end
            DRAIN: begin
                TrapStall = 1'b1;
                TrapFlush = 1'b1;
            end
            REDIRECT: begin
                TrapFlush = 1'b1;
                TrapPCSel = 1'b1;
                TrapPC    = ret ? Mepc : Mtvec;
            end
            HALT: begin
                TrapStall = 1'b1;
                TrapFlush = 1'b1;
                Halted    = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer state, drain counter and trap CSRs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            ret    <= 1'b0;
            Mepc   <= '0;
            Mcause <= '0;
            Mtvec  <= {MTVEC_RESET[XLEN-1:2], 2'b00};
        end else begin
            // Direct mode only: the low two bits of mtvec are forced to zero
            if (MtvecWrE && (state != HALT))
                Mtvec <= {MtvecWdata[XLEN-1:2], 2'b00};
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (EbreakE) begin
                            Mepc   <= PCE;
                            Mcause <= CAUSE_EBREAK;
                            if (HALT_ON_EBREAK) begin
                                state <= HALT;
                            end else begin
                                ret   <= 1'b0;
                                cnt   <= CNT_INIT;
                                state <= DRAIN;
                            end
                        end else if (EcallE) begin
                            Mepc   <= PCE;
                            Mcause <= CAUSE_ECALL;
                            ret    <= 1'b0;
                            cnt    <= CNT_INIT;
                            state  <= DRAIN;
                        end else begin
                            // MRET: nothing older can still write the CSRs, so redirect at once
                            ret   <= 1'b1;
                            state <= REDIRECT;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == '0)
                        state <= REDIRECT;
                    else
                        cnt <= cnt - 1'b1;
                end
                REDIRECT: state <= IDLE;
                HALT:     state <= HALT;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - randomized model-checked bench for trap_ctrl
module tb_trap_ctrl;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ecall = 1'b0, ebreak = 1'b0, mret = 1'b0, stalle = 1'b0, wr = 1'b0;
    logic [31:0] pce = '0, wdata = '0;

    logic        o_stall [2];
    logic        o_flush [2];
    logic        o_pcsel [2];
    logic        o_halt  [2];
    logic [31:0] o_pc    [2];
    logic [31:0] o_mepc  [2];
    logic [31:0] o_mcause[2];
    logic [31:0] o_mtvec [2];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(32), .DRAIN_CYCLES(DRAIN), .MTVEC_RESET(32'h0000_0100), .HALT_ON_EBREAK(1'b0)) dut0 (
        .clk(clk), .reset(reset), .EcallE(ecall), .EbreakE(ebreak), .MretE(mret), .StallE(stalle),
        .PCE(pce), .MtvecWrE(wr), .MtvecWdata(wdata),
        .TrapStall(o_stall[0]), .TrapFlush(o_flush[0]), .TrapPCSel(o_pcsel[0]), .TrapPC(o_pc[0]),
        .Mepc(o_mepc[0]), .Mcause(o_mcause[0]), .Mtvec(o_mtvec[0]), .Halted(o_halt[0])
    );

    trap_ctrl #(.XLEN(32), .DRAIN_CYCLES(DRAIN), .MTVEC_RESET(32'h0000_0100), .HALT_ON_EBREAK(1'b1)) dut1 (
        .clk(clk), .reset(reset), .EcallE(ecall), .EbreakE(ebreak), .MretE(mret), .StallE(stalle),
        .PCE(pce), .MtvecWrE(wr), .MtvecWdata(wdata),
        .TrapStall(o_stall[1]), .TrapFlush(o_flush[1]), .TrapPCSel(o_pcsel[1]), .TrapPC(o_pc[1]),
        .Mepc(o_mepc[1]), .Mcause(o_mcause[1]), .Mtvec(o_mtvec[1]), .Halted(o_halt[1])
    );

    // Reference model: cycles-until-redirect countdown plus CSR values
    logic [31:0] m_mtvec [2];
    logic [31:0] m_mepc  [2];
    logic [31:0] m_mcause[2];
    logic        m_ret   [2];
    int          m_pend  [2];
    logic        m_halt  [2];
    logic        halt_cfg[2];
    logic [163:0] e_vec, a_vec;
    logic        e_stall, e_flush, e_pcsel, e_halt, acc;
    logic [31:0] e_pc;

    initial begin
        halt_cfg[0] = 1'b0;
        halt_cfg[1] = 1'b1;
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            e_stall = 1'b0; e_flush = 1'b0; e_pcsel = 1'b0; e_halt = 1'b0; e_pc = '0;
            acc = !stalle && (ecall || ebreak || mret);
            if (reset) begin
                m_mtvec[d] = 32'h100; m_mepc[d] = '0; m_mcause[d] = '0;
                m_ret[d] = 1'b0; m_pend[d] = -1; m_halt[d] = 1'b0;
            end else if (m_halt[d]) begin
                e_stall = 1'b1; e_flush = 1'b1; e_halt = 1'b1;
            end else if (m_pend[d] == 0) begin
                e_pcsel = 1'b1; e_flush = 1'b1;
                e_pc = m_ret[d] ? m_mepc[d] : m_mtvec[d];
            end else if (m_pend[d] > 0) begin
                e_stall = 1'b1; e_flush = 1'b1;
            end else begin
                e_stall = acc; e_flush = acc;
            end
            e_vec = {e_stall, e_flush, e_pcsel, e_halt, e_pc, m_mepc[d], m_mcause[d], m_mtvec[d]};
            a_vec = {o_stall[d], o_flush[d], o_pcsel[d], o_halt[d], o_pc[d], o_mepc[d], o_mcause[d], o_mtvec[d]};
            n_chk++;
            if (a_vec === e_vec) n_pass++;
            else $display("FAIL model dut%0d cycle %0d: got stall/flush/sel/halt=%b pc=%h mepc=%h mcause=%h mtvec=%h, want %b pc=%h mepc=%h mcause=%h mtvec=%h",
                          d, cyc, a_vec[163:160], a_vec[159:128], a_vec[127:96], a_vec[95:64], a_vec[63:32],
                          e_vec[163:160], e_vec[159:128], e_vec[127:96], e_vec[95:64], e_vec[63:32]);
            if (!reset) begin
                if (!m_halt[d] && wr) m_mtvec[d] = wdata & ~32'd3;
                if (m_halt[d]) begin
                end else if (m_pend[d] > 0) m_pend[d] = m_pend[d] - 1;
                else if (m_pend[d] == 0) m_pend[d] = -1;
                else if (acc) begin
                    if (ebreak || ecall) begin
                        m_mepc[d]   = pce;
                        m_mcause[d] = ebreak ? 32'd3 : 32'd11;
                        if (ebreak && halt_cfg[d]) m_halt[d] = 1'b1;
                        else begin m_ret[d] = 1'b0; m_pend[d] = DRAIN; end
                    end else begin
                        m_ret[d] = 1'b1; m_pend[d] = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic step(input logic r, input logic e, input logic b, input logic m, input logic s,
                        input logic [31:0] pc, input logic w, input logic [31:0] wd);
        @(posedge clk);
        #1;
        reset = r; ecall = e; ebreak = b; mret = m; stalle = s; pce = pc; wr = w; wdata = wd;
        @(negedge clk);
    endtask

    int cnt_ps, bad;

    initial begin
        @(negedge clk);
        chk("reset mtvec", o_mtvec[0], 32'h100);
        chk("reset mepc", o_mepc[0], 32'h0);
        chk("reset stall/sel/halt", {29'd0, o_stall[0], o_pcsel[0], o_halt[0]}, 32'h0);

        step(0, 0, 0, 0, 0, 32'h0, 1, 32'h200);
        step(0, 1, 0, 0, 0, 32'h40, 0, 0);
        chk("ecall accept stall/flush", {30'd0, o_stall[0], o_flush[0]}, 32'h3);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("drain1 stall", {31'd0, o_stall[0]}, 32'h1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("drain2 stall", {31'd0, o_stall[0]}, 32'h1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("redirect sel", {31'd0, o_pcsel[0]}, 32'h1);
        chk("redirect pc", o_pc[0], 32'h200);
        chk("ecall mepc", o_mepc[0], 32'h40);
        chk("ecall mcause", o_mcause[0], 32'd11);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'h999, 0, 0);
        chk("mret accept stall", {31'd0, o_stall[0]}, 32'h1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mret sel", {31'd0, o_pcsel[0]}, 32'h1);
        chk("mret pc", o_pc[0], 32'h40);
        chk("mret mcause kept", o_mcause[0], 32'd11);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        step(0, 1, 1, 0, 0, 32'h80, 0, 0);
        cnt_ps = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, i == 1, 0, 0, 0, 32'h44, 0, 0);
            cnt_ps += int'(o_pcsel[0]);
        end
        chk("single redirect", cnt_ps, 1);
        chk("ebreak mcause", o_mcause[0], 32'd3);
        chk("halt mepc", o_mepc[1], 32'h80);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            if (!o_halt[1] || !o_stall[1] || o_pcsel[1]) bad++;
        end
        chk("halt held", bad, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset halted", {31'd0, o_halt[1]}, 32'h0);
        chk("reset mepc1", o_mepc[1], 32'h0);
        chk("reset mcause1", o_mcause[1], 32'h0);

        step(0, 1, 0, 0, 1, 32'h60, 0, 0);
        chk("stalled no accept", {31'd0, o_stall[0]}, 32'h0);
        step(0, 1, 0, 0, 0, 32'h60, 0, 0);
        chk("unstalled accept", {31'd0, o_stall[0]}, 32'h1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0);

        step(0, 1, 0, 0, 0, 32'h10, 1, 32'h303);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mtvec write seen", o_pc[0], 32'h300);

        step(0, 1, 0, 0, 0, 32'h20, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        cnt_ps = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            cnt_ps += int'(o_pcsel[0]);
        end
        chk("reset aborts redirect", cnt_ps, 0);

        for (int i = 0; i < 1500; i++) begin
            logic r;
            r = ($urandom_range(0, 99) < 2);
            step(r,
                 !r && ($urandom_range(0, 99) < 12),
                 !r && ($urandom_range(0, 99) < 5),
                 !r && ($urandom_range(0, 99) < 10),
                 $urandom_range(0, 99) < 20,
                 $urandom,
                 $urandom_range(0, 99) < 6,
                 $urandom);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
